encoder8to3_stream: RTL



---
 rtl/encoder8to3_stream.sv | 63 ++++++
 1 files changed

// File: rtl/encoder8to3_stream.sv
// encoder8to3_stream: drains a multi-hot 8-bit request vector into a stream of 3-bit indices
module encoder8to3_stream #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_vec,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_zero
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_n;
  logic [7:0] pend, pend_n;
  logic       zero, zero_n;
  logic [2:0] idx;
  logic       last;
  logic       drain;
  assign drain     = state == DRAIN;
  assign last      = zero | (pend != 8'd0 && (pend & (pend - 8'd1)) == 8'd0);
  assign in_ready  = ~drain & ~rst;
  assign out_valid = drain;
  assign out_idx   = drain ? idx : 3'd0;
  assign out_last  = drain & last;
  assign out_zero  = drain & zero;
  // priority pick: the last matching bit scanned wins, so scan from the far end toward the winner
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (pend[LOW_FIRST ? 7 - i : i]) idx = LOW_FIRST ? 3'(7 - i) : 3'(i);
  end
  // accept a vector in IDLE; retire one beat per transfer in DRAIN
  always_comb begin
    state_n = state;
    pend_n  = pend;
    zero_n  = zero;
    if (!drain && in_valid) begin
      state_n = DRAIN;
      pend_n  = in_vec;
      zero_n  = in_vec == 8'd0;
    end else if (drain && out_ready) begin
      pend_n  = pend & ~(8'd1 << idx);
      zero_n  = 1'b0;
      state_n = last ? IDLE : DRAIN;
    end
  end
  // state, pending bits and zero marker registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 8'd0;
      zero  <= 1'b0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      zero  <= zero_n;
    end
  end
endmodule
